// File: rtl/mapper_arb_pkg.sv
// Shared types for the mapper memory arbiter: lock FSM states,
// read-owner tag values and the default starvation limit.
package mapper_arb_pkg;

  typedef enum logic [1:0] {
    ST_STREAM,
    ST_DRAIN,
    ST_CFG
  } arb_state_t;

  localparam logic TAG_LOOKUP = 1'b0;
  localparam logic TAG_CFG    = 1'b1;

  localparam int STARVE_MAX_DEF = 16;

endpackage

// File: rtl/mapper_arb_tag_fifo.sv
// 1-bit tag FIFO remembering which requester owns each outstanding read.
// Ports: push/push_tag in, pop in, full/empty/head out; clk, rstf (async low).
module mapper_arb_tag_fifo #(
  parameter int TAG_DEPTH = 4
) (
  input  logic clk,
  input  logic rstf,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PW = $clog2(TAG_DEPTH);

  logic [TAG_DEPTH-1:0] mem;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [PW:0]          count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = count == (PW+1)'(TAG_DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_tag;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, do_push}
                     - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/mapper_mem_arbiter.sv
// Arbitrates lookup stream and config port onto one mapper memory port,
// routes read responses by owner tag, and grants config an exclusive lock.
// Ports: l_* lookup, c_* config (+c_lock/c_lock_ack), m_* memory; clk, rstf.
// Build option: MAPPER_ARB_STARVE_EN forces a config grant after
// STARVE_MAX cycles of waiting behind lookups.
module mapper_mem_arbiter
  import mapper_arb_pkg::*;
#(
  parameter  int DEPTH      = 8,
  parameter  int TAG_DEPTH  = 4,
  parameter  int STARVE_MAX = STARVE_MAX_DEF,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstf,
  input  logic [AW-1:0] l_addr,
  input  logic          l_valid,
  output logic          l_ready,
  output logic [31:0]   l_data,
  output logic          l_dvalid,
  input  logic          l_dready,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wdata,
  input  logic          c_we,
  input  logic          c_valid,
  output logic          c_ready,
  output logic [31:0]   c_rdata,
  output logic          c_rvalid,
  input  logic          c_rready,
  input  logic          c_lock,
  output logic          c_lock_ack,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_data,
  output logic          m_we,
  output logic          m_valid,
  input  logic          m_ready,
  input  logic [31:0]   m_rdata,
  input  logic          m_rvalid,
  output logic          m_rready
);

  if (TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_bad_tag
    $error("TAG_DEPTH must be a power of 2 and at least 2");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("STARVE_MAX must be at least 1");
  end

  arb_state_t state;
  logic       gnt_l;
  logic       gnt_c;
  logic       starve_hit;
  logic       tag_full;
  logic       tag_empty;
  logic       tag_head;
  logic       rd_ok;
  logic       push;
  logic       pop;
  logic       rsp_ok;

  // Grants require the requester's valid so ready never idles high.
  always_comb begin
    gnt_l = 1'b0;
    gnt_c = 1'b0;
    unique case (state)
      ST_STREAM: begin
        if (starve_hit && c_valid)
          gnt_c = 1'b1;
        else if (l_valid)
          gnt_l = 1'b1;
        else
          gnt_c = c_valid;
      end
      ST_CFG:  gnt_c = c_valid;
      default: ;
    endcase
  end

  // Reads need a free tag slot; a same-cycle pop does not free one.
  assign rd_ok   = ~tag_full;
  assign l_ready = gnt_l & m_ready & rd_ok;
  assign c_ready = gnt_c & m_ready & (c_we | rd_ok);
  assign m_valid = (gnt_l & rd_ok) | (gnt_c & (c_we | rd_ok));
  assign m_addr  = gnt_c ? c_addr : l_addr;
  assign m_data  = c_wdata;
  assign m_we    = gnt_c & c_we;
  assign push    = l_ready | (c_ready & ~c_we);

  assign rsp_ok   = m_rvalid & ~tag_empty;
  assign l_dvalid = rsp_ok & (tag_head == TAG_LOOKUP);
  assign c_rvalid = rsp_ok & (tag_head == TAG_CFG);
  assign l_data   = m_rdata;
  assign c_rdata  = m_rdata;
  assign m_rready = ~tag_empty & (tag_head ? c_rready : l_dready);
  assign pop      = rsp_ok & m_rready;

  mapper_arb_tag_fifo #(
    .TAG_DEPTH(TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rstf    (rstf),
    .push    (push),
    .push_tag(gnt_c ? TAG_CFG : TAG_LOOKUP),
    .pop     (pop),
    .full    (tag_full),
    .empty   (tag_empty),
    .head    (tag_head)
  );

  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state      <= ST_STREAM;
      c_lock_ack <= 1'b0;
    end else begin
      unique case (state)
        ST_STREAM: if (c_lock) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (!c_lock) begin
            state <= ST_STREAM;
          end else if (tag_empty && !m_rvalid) begin
            state      <= ST_CFG;
            c_lock_ack <= 1'b1;
          end
        end
        ST_CFG: begin
          if (!c_lock) begin
            state      <= ST_STREAM;
            c_lock_ack <= 1'b0;
          end
        end
        default: state <= ST_STREAM;
      endcase
    end
  end

`ifdef MAPPER_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_cnt;

  assign starve_hit = starve_cnt == SW'(STARVE_MAX);

  // c_lock in ST_STREAM means the state is being left this edge.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf)
      starve_cnt <= '0;
    else if (state != ST_STREAM || c_lock || c_ready)
      starve_cnt <= '0;
    else if (c_valid && !starve_hit)
      starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign starve_hit = 1'b0;
`endif

  a_no_orphan_rsp: assert property (
    @(posedge clk) disable iff (!rstf) !(m_rvalid && tag_empty)
  );

endmodule

// File: tb/tb_mapper_mem_arbiter.sv
// Scoreboard bench for mapper_mem_arbiter with a 1-cycle memory model.
// Issue tracker pushes expected data; response monitor pops and compares.
module tb_mapper_mem_arbiter;

  localparam int AW = 3;
  localparam logic [31:0] QAM [8] = '{
    32'h0003_0003, 32'h0003_0001, 32'h0001_0003, 32'h0001_0001,
    32'h0003_FFFD, 32'h0003_FFFF, 32'h0001_FFFD, 32'h0001_FFFF
  };

  logic          clk = 1'b0;
  logic          rstf;
  logic [AW-1:0] l_addr;
  logic          l_valid;
  logic          l_ready;
  logic [31:0]   l_data;
  logic          l_dvalid;
  logic          l_dready;
  logic [AW-1:0] c_addr;
  logic [31:0]   c_wdata;
  logic          c_we;
  logic          c_valid;
  logic          c_ready;
  logic [31:0]   c_rdata;
  logic          c_rvalid;
  logic          c_rready;
  logic          c_lock;
  logic          c_lock_ack;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  logic          m_we;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_rdata;
  logic          m_rvalid;
  logic          m_rready;

  always #5 clk = ~clk;

  mapper_mem_arbiter dut (
    .clk(clk), .rstf(rstf),
    .l_addr(l_addr), .l_valid(l_valid), .l_ready(l_ready),
    .l_data(l_data), .l_dvalid(l_dvalid), .l_dready(l_dready),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_we(c_we),
    .c_valid(c_valid), .c_ready(c_ready),
    .c_rdata(c_rdata), .c_rvalid(c_rvalid), .c_rready(c_rready),
    .c_lock(c_lock), .c_lock_ack(c_lock_ack),
    .m_addr(m_addr), .m_data(m_data), .m_we(m_we),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  int checks = 0;
  int errors = 0;
  int l_seen = 0;
  int c_seen = 0;
  logic [31:0] last_l;
  logic [31:0] mem [8];
  logic [31:0] ref_mem [8];
  logic [31:0] rsp_q [$];
  logic [31:0] exp_l [$];
  logic [31:0] exp_c [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: accepts when t_ready, answers one cycle later, holds on i_ready=0.
  always @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      rsp_q.delete();
      for (int i = 0; i < 8; i++) mem[i] <= QAM[i];
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
    end else begin
      if (m_rvalid && m_rready) void'(rsp_q.pop_front());
      if (m_valid && m_ready) begin
        if (m_we) mem[m_addr] <= m_data;
        else rsp_q.push_back(mem[m_addr]);
      end
      m_rvalid <= rsp_q.size() != 0;
      m_rdata  <= (rsp_q.size() != 0) ? rsp_q[0] : '0;
    end
  end

  // Issue tracker: reference table and expected-response queues.
  always @(negedge clk) begin
    if (!rstf) begin
      for (int i = 0; i < 8; i++) ref_mem[i] = QAM[i];
    end else begin
      if (l_valid && l_ready) exp_l.push_back(ref_mem[l_addr]);
      if (c_valid && c_ready) begin
        if (c_we) ref_mem[c_addr] = c_wdata;
        else exp_c.push_back(ref_mem[c_addr]);
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rstf) begin
      if (l_dvalid && l_dready) begin
        l_seen++;
        last_l = l_data;
        if (exp_l.size() == 0) begin
          checks++; errors++;
          $display("FAIL l_unexpected: got %h, want none", l_data);
        end else chk("l_data", l_data, exp_l.pop_front());
      end
      if (c_rvalid && c_rready) begin
        c_seen++;
        if (exp_c.size() == 0) begin
          checks++; errors++;
          $display("FAIL c_unexpected: got %h, want none", c_rdata);
        end else chk("c_rdata", c_rdata, exp_c.pop_front());
      end
    end
  end

  task automatic drain(string name);
    int n = 0;
    while ((exp_l.size() + exp_c.size()) != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_l.size() + exp_c.size()), 0);
  endtask

  initial begin
    int bl, bc, n, waited;
    logic got;
    rstf = 1'b0;
    l_addr = '0; l_valid = 0; l_dready = 1;
    c_addr = '0; c_wdata = '0; c_we = 0; c_valid = 0;
    c_rready = 1; c_lock = 0; m_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_lock_ack", 32'(c_lock_ack), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_l_dvalid", 32'(l_dvalid), 0);
    chk("rst_c_rvalid", 32'(c_rvalid), 0);
    step(); rstf = 1'b1;

    // Streaming lookups 0..7
    bl = l_seen;
    for (int i = 0; i < 8; i++) begin
      step(); l_addr = AW'(i); l_valid = 1;
      @(negedge clk); chk("t1_l_ready", 32'(l_ready), 1);
    end
    step(); l_valid = 0;
    drain("t1_drain");
    chk("t1_count", 32'(l_seen - bl), 8);

    // Config write then lookup readback
    step(); c_addr = 3; c_wdata = 32'hDEADBEEF; c_we = 1; c_valid = 1;
    @(negedge clk); chk("t2_c_ready", 32'(c_ready), 1);
    step(); c_valid = 0; c_we = 0;
    @(negedge clk); chk("t2_c_ready_low", 32'(c_ready), 0);
    step(); l_addr = 3; l_valid = 1;
    @(negedge clk); chk("t2_l_ready", 32'(l_ready), 1);
    step(); l_valid = 0;
    drain("t2_drain");
    chk("t2_readback", last_l, 32'hDEADBEEF);

    // Interleaved lookup and config read
    bl = l_seen; bc = c_seen;
    step(); l_addr = 1; l_valid = 1;
    step(); l_valid = 0; c_addr = 2; c_we = 0; c_valid = 1;
    @(negedge clk); chk("t3_c_ready", 32'(c_ready), 1);
    step(); c_valid = 0;
    drain("t3_drain");
    chk("t3_l_cnt", 32'(l_seen - bl), 1);
    chk("t3_c_cnt", 32'(c_seen - bc), 1);

    // Lock with 3 lookups in flight
    l_dready = 0;
    for (int i = 4; i < 7; i++) begin
      step(); l_addr = AW'(i); l_valid = 1;
    end
    step(); l_valid = 0; c_lock = 1;
    for (int k = 0; k < 5; k++) begin
      step(); l_addr = 0; l_valid = 1;
      @(negedge clk);
      chk("t4_ack_drain", 32'(c_lock_ack), 0);
      chk("t4_l_ready_drain", 32'(l_ready), 0);
    end
    step(); l_dready = 1;
    n = 0;
    while (!c_lock_ack && n < 20) begin
      @(negedge clk);
      n++;
      if (!c_lock_ack) chk("t4_l_ready_wait", 32'(l_ready), 0);
    end
    chk("t4_ack_rise", 32'(c_lock_ack), 1);
    chk("t4_drained", 32'(exp_l.size()), 0);
    chk("t4_l_ready_cfg", 32'(l_ready), 0);
    step(); c_addr = 5; c_we = 0; c_valid = 1;
    @(negedge clk);
    chk("t4_c_ready_cfg", 32'(c_ready), 1);
    chk("t4_l_ready_cfg2", 32'(l_ready), 0);
    step(); c_valid = 0; c_lock = 0;
    @(negedge clk); chk("t4_l_ready_last", 32'(l_ready), 0);
    step();
    @(negedge clk);
    chk("t4_ack_clear", 32'(c_lock_ack), 0);
    chk("t4_l_resume", 32'(l_ready), 1);
    step(); l_valid = 0;
    drain("t4_drain");

    // Tag FIFO full
    l_dready = 0;
    for (int i = 0; i < 4; i++) begin
      step(); l_addr = AW'(i); l_valid = 1;
      @(negedge clk); chk("t5_l_ready", 32'(l_ready), 1);
    end
    step(); l_addr = 4;
    @(negedge clk); chk("t5_full_block", 32'(l_ready), 0);
    step();
    @(negedge clk); chk("t5_full_block2", 32'(l_ready), 0);
    step(); l_dready = 1;
    @(negedge clk); chk("t5_full_on_pop", 32'(l_ready), 0);
    step();
    @(negedge clk); chk("t5_after_pop", 32'(l_ready), 1);
    step(); l_valid = 0;
    drain("t5_drain");

    // Config starvation under continuous lookups
    step(); l_addr = 0; l_valid = 1;
    c_addr = 7; c_wdata = 32'h1234_5678; c_we = 1; c_valid = 1;
    waited = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (c_ready) got = 1;
      else begin
        waited++;
        step(); l_addr = AW'(k + 1);
      end
    end
    step(); c_valid = 0; c_we = 0; l_valid = 0;
`ifdef MAPPER_ARB_STARVE_EN
    chk("t6_accepted", 32'(got), 1);
    chk("t6_wait", 32'(waited), 16);
`else
    chk("t6_never", 32'(got), 0);
    chk("t6_wait", 32'(waited), 40);
`endif
    drain("t6_drain");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mapper_mem_arbiter.md
Name: mapper_mem_arbiter

Overview:
- Shares one mapper_memory port between two requesters.
  - The symbol lookup stream (read-only, throughput critical).
  - The configuration/CPU port (table writes and readback).
- Issues requests to the memory's t_* handshake and tracks the owner of each outstanding read with a tag FIFO.
- Routes i_* responses back to the requester that issued the read.
- A lock FSM gives config exclusive access for table reloads, after draining in-flight lookups.

Parameters:
- DEPTH, 8: mapper table depth; address width AW = $clog2(DEPTH).
- TAG_DEPTH, 4: outstanding-read tag FIFO entries; power of 2, minimum 2.
- STARVE_MAX, 16: cycles a pending config request waits before a forced grant (optional feature only).

Ports:
- clk  in  1  clock
- rstf  in  1  asynchronous active-low reset
- l_addr  in  AW  lookup read address (symbol index)
- l_valid  in  1  lookup request valid
- l_ready  out  1  lookup request accepted
- l_data  out  32  lookup response data
- l_dvalid  out  1  lookup response valid
- l_dready  in  1  lookup response ready
- c_addr  in  AW  config address
- c_wdata  in  32  config write data
- c_we  in  1  1 = write, 0 = read
- c_valid  in  1  config request valid
- c_ready  out  1  config request accepted
- c_rdata  out  32  config readback data
- c_rvalid  out  1  config readback valid
- c_rready  in  1  config readback ready
- c_lock  in  1  request exclusive config ownership
- c_lock_ack  out  1  exclusive ownership granted
- m_addr  out  AW  to memory t_addr
- m_data  out  32  to memory t_data
- m_we  out  1  to memory t_we
- m_valid  out  1  to memory t_valid
- m_ready  in  1  from memory t_ready
- m_rdata  in  32  from memory i_data
- m_rvalid  in  1  from memory i_valid
- m_rready  out  1  to memory i_ready

Behaviour:
- Reset and clocking:
  - rstf is asynchronous, active-low; clk is the clock.
  - On reset: state = ST_STREAM, c_lock_ack = 0, tag FIFO empty (rd_ptr = wr_ptr = 0, count = 0), starve counter = 0.
  - Reset mid-operation discards all tags. The memory shares rstf, so its i_valid also clears and no orphan response can exist.
- Request issue:
  - The grant is combinational on the current cycle. Exactly one requester is selected.
  - m_addr, m_data and m_we are muxed from the selected requester. m_valid = selected valid, with reads additionally gated by ~tag_full.
  - A request is accepted when the requester's valid is high, it is granted, m_ready = 1 and, for reads, the tag FIFO is not full.
  - l_ready and c_ready are high only for the granted requester under the same conditions.
- Tags:
  - An accepted read pushes a tag: 0 = lookup, 1 = config. Writes push no tag.
  - tag_full blocks reads even when a pop occurs in the same cycle. Push and pop in the same cycle on a non-full, non-empty FIFO keep the count unchanged.
- Response routing:
  - Routing follows the head tag. l_dvalid = m_rvalid & ~head; c_rvalid = m_rvalid & head.
  - l_data = c_rdata = m_rdata.
  - m_rready = head ? c_rready : l_dready.
  - A pop occurs on m_rvalid & m_rready.
  - m_rvalid with an empty FIFO is illegal (assertion). Outputs stay 0 in that case.
- FSM:
  - ST_STREAM:
    - Lookup has fixed priority; config is granted only when l_valid = 0.
    - c_lock = 1 moves to ST_DRAIN.
  - ST_DRAIN:
    - No new grants to either requester.
    - Moves to ST_CFG when the tag FIFO is empty and m_rvalid = 0.
    - c_lock falling moves back to ST_STREAM.
  - ST_CFG:
    - Only config is granted. l_ready = 0. c_lock_ack = 1 (registered; asserts the cycle the state is entered).
    - c_lock falling moves to ST_STREAM and clears c_lock_ack the same edge.
- Timing:
  - Issue adds zero latency. Read response arrives one cycle after acceptance, per the memory.
  - Back-to-back lookups sustain 1 read/cycle while l_dready = 1.
- Assertion: c_lock toggling within ST_DRAIN is legal and needs no extra handling.

Optional Feature:
- Macro: MAPPER_ARB_STARVE_EN.
- Defined:
  - A counter increments in ST_STREAM while c_valid = 1 and config is not accepted. It saturates at STARVE_MAX.
  - At STARVE_MAX, config gets priority over lookup until one config request is accepted; the counter then clears.
  - The counter clears on any config acceptance and on leaving ST_STREAM.
- Undefined: strict lookup priority; config can starve indefinitely under continuous l_valid. The counter logic is absent.

Decomposition:
- Package mapper_arb_pkg:
  - State enum {ST_STREAM, ST_DRAIN, ST_CFG}.
  - Tag constants TAG_LOOKUP = 1'b0, TAG_CFG = 1'b1.
  - Default STARVE_MAX.
- One sub-module, mapper_arb_tag_fifo: 1-bit-wide, TAG_DEPTH-deep, registered-pointer FIFO with full/empty/head outputs.

Test Plan:
- Continuous lookups addr 0..7, l_dready = 1, memory preloaded qam16 table -> l_dvalid every cycle from cycle 2. Data equals mem[addr] in order. c_rvalid never set.
- Config write addr 3 = 0xDEADBEEF with l_valid = 0, then lookup addr 3 -> c_ready pulses once; l_data = 0xDEADBEEF.
- Interleaved lookup read addr 1 and config read addr 2, with config accepted the cycle after lookup -> l_dvalid carries mem[1] and c_rvalid carries mem[2], each once, in issue order.
- Assert c_lock with 3 lookups in flight and l_dready held 0 for 5 cycles -> c_lock_ack stays 0 until all 3 responses drain, then rises. l_ready = 0 throughout ST_CFG. Deassert -> lookups resume next cycle.
- Tag FIFO full: TAG_DEPTH = 4, l_dready = 0, 4 lookups accepted (memory backpressure permitting) -> the 5th l_ready = 0 until one response pops.
- With MAPPER_ARB_STARVE_EN, STARVE_MAX = 16, l_valid = 1 forever, c_valid = 1 -> config accepted exactly after 16 waiting cycles. Without the macro -> config never accepted.
